// File: rtl/uart_ram_ctrl.sv
// uart_ram_ctrl: ring-buffer byte FIFO controller for the uart_ram simple
// dual-port RAM. Registered RAM write and read ports, a 2-entry output buffer
// that hides the one-cycle RAM read, level/full/empty status and a sticky
// overflow flag.
// Optional feature: define UART_RAM_CTRL_WM_EN to add parameter AFULL_LEVEL
// and the registered afull watermark output.
module uart_ram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 8
`ifdef UART_RAM_CTRL_WM_EN
  ,
  parameter int unsigned AFULL_LEVEL = (2 ** ADDR_WIDTH) - 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  ovf_err,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
`ifdef UART_RAM_CTRL_WM_EN
  ,
  output logic                  afull
`endif
);

  localparam logic [ADDR_WIDTH:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LVL_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [ADDR_WIDTH:0]   unfetched_q, unfetched_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  ovf_q, ovf_d;
  logic                  ram_wr_en_q, ram_wr_en_d;
  logic [ADDR_WIDTH-1:0] ram_wr_addr_q, ram_wr_addr_d;
  logic [DATA_WIDTH-1:0] ram_wr_data_q, ram_wr_data_d;
  logic [ADDR_WIDTH-1:0] ram_rd_addr_q, ram_rd_addr_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic       push;
  logic       pop;
  logic       commit;
  logic       fetch;
  logic [1:0] occ;
  logic [1:0] occ_after;

  assign in_ready    = ~full_q;
  assign out_valid   = (buf_cnt_q != 2'd0);
  assign out_data    = buf0_q;
  assign level       = level_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign ovf_err     = ovf_q;
  assign ram_wr_en   = ram_wr_en_q;
  assign ram_wr_addr = ram_wr_addr_q;
  assign ram_wr_data = ram_wr_data_q;
  assign ram_rd_addr = ram_rd_addr_q;

  // Handshakes and read-issue decision.
  // The slot freed by a pop at this edge is reused by a fetch at the same
  // edge; without that lookahead two buffer entries cannot sustain 1 byte/cycle.
  always_comb begin
    push      = in_valid & ~full_q;
    pop       = out_valid & out_ready;
    commit    = ram_wr_en_q;
    occ       = buf_cnt_q + {1'b0, inflight_q};
    occ_after = occ - {1'b0, pop};
    fetch     = (unfetched_q != '0) && (occ_after < 2'd2);
  end

  // Pointers, occupancy, status flags and RAM port registers.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    unfetched_d   = unfetched_q;
    ram_wr_en_d   = push;
    ram_wr_addr_d = ram_wr_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    ram_rd_addr_d = ram_rd_addr_q;
    ovf_d         = ovf_q | (in_valid & full_q);

    if (push) begin
      wr_ptr_d      = wr_ptr_q + PTR_ONE;
      ram_wr_addr_d = wr_ptr_q;
      ram_wr_data_d = in_data;
    end

    if (fetch) begin
      rd_ptr_d      = rd_ptr_q + PTR_ONE;
      ram_rd_addr_d = rd_ptr_q;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    unique case ({commit, fetch})
      2'b10:   unfetched_d = unfetched_q + LVL_ONE;
      2'b01:   unfetched_d = unfetched_q - LVL_ONE;
      default: unfetched_d = unfetched_q;
    endcase

    if (flush) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      level_d       = '0;
      unfetched_d   = '0;
      ram_wr_en_d   = 1'b0;
      ram_wr_addr_d = ram_wr_addr_q;
      ram_wr_data_d = ram_wr_data_q;
      ram_rd_addr_d = ram_rd_addr_q;
      ovf_d         = 1'b0;
    end

    full_d  = (level_d == DEPTH);
    empty_d = (level_d == '0);
  end

  // Two-entry output buffer fed by the RAM read one cycle after issue.
  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    buf_cnt_d  = buf_cnt_q;
    inflight_d = fetch;

    unique case ({inflight_q, pop})
      2'b10: begin
        if (buf_cnt_q == 2'd0) begin
          buf0_d = ram_rd_data;
        end else begin
          buf1_d = ram_rd_data;
        end
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf0_d = ram_rd_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = ram_rd_data;
        end
      end
      default: begin
        buf_cnt_d = buf_cnt_q;
      end
    endcase

    if (flush) begin
      buf0_d     = '0;
      buf1_d     = '0;
      buf_cnt_d  = '0;
      inflight_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      unfetched_q   <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      ovf_q         <= 1'b0;
      ram_wr_en_q   <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
      ram_rd_addr_q <= '0;
      inflight_q    <= 1'b0;
      buf_cnt_q     <= '0;
      buf0_q        <= '0;
      buf1_q        <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      unfetched_q   <= unfetched_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      ovf_q         <= ovf_d;
      ram_wr_en_q   <= ram_wr_en_d;
      ram_wr_addr_q <= ram_wr_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      ram_rd_addr_q <= ram_rd_addr_d;
      inflight_q    <= inflight_d;
      buf_cnt_q     <= buf_cnt_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
    end
  end

`ifdef UART_RAM_CTRL_WM_EN
  localparam logic [ADDR_WIDTH:0] AFULL_THR = (ADDR_WIDTH + 1)'(AFULL_LEVEL);

  logic afull_q, afull_d;

  assign afull = afull_q;

  // Almost-full watermark, derived from the next level so it tracks level.
  always_comb begin
    afull_d = flush ? 1'b0 : (level_d >= AFULL_THR);
  end

  // Watermark register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= afull_d;
    end
  end
`else
  // Watermark output not built.
`endif

endmodule

// File: tb/tb_uart_ram_ctrl.sv
// Self-checking bench for uart_ram_ctrl: a RAM model, a queue-based FIFO
// reference checked on every falling edge, and directed literal checks.
module tb_uart_ram_ctrl;

  localparam int AW    = 15;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          ovf_err;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
`ifdef UART_RAM_CTRL_WM_EN
  logic          afull;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .flush       (flush),
    .level       (level),
    .full        (full),
    .empty       (empty),
    .ovf_err     (ovf_err),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
`ifdef UART_RAM_CTRL_WM_EN
    ,
    .afull       (afull)
`endif
  );

  // RAM: write commits at the clock edge, read data follows the address.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
  end
  assign ram_rd_data = mem[ram_rd_addr];

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: ordered queue of accepted bytes stamped with their push edge.
  typedef struct {
    logic [DW-1:0] data;
    int            stamp;
  } ent_t;

  ent_t q[$];
  int   ecount = 0;
  bit   m_ovf = 0;
  int   m_wptr = 0;
  bit   m_wr_en = 0;
  int   m_wr_addr = 0;
  int   m_wr_data = 0;
  bit   prev_stall = 0;
  int   prev_data = 0;

  always @(posedge clk) ecount <= ecount + 1;

  always @(negedge clk) begin : compare
    bit   ev;
    bit   mpush;
    bit   mpop;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_wptr = 0; m_wr_en = 0; prev_stall = 0;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_ovf_err", int'(ovf_err), 0);
      chk("rst_ram_wr_en", int'(ram_wr_en), 0);
      chk("rst_ram_wr_addr", int'(ram_wr_addr), 0);
      chk("rst_ram_wr_data", int'(ram_wr_data), 0);
      chk("rst_ram_rd_addr", int'(ram_rd_addr), 0);
    end else begin
      // A byte pushed at edge k is presentable after edge k+3.
      ev = (q.size() > 0) && (q[0].stamp + 3 <= ecount);
      chk("level", int'(level), q.size());
      chk("full", int'(full), int'(q.size() == DEPTH));
      chk("empty", int'(empty), int'(q.size() == 0));
      chk("in_ready", int'(in_ready), int'(q.size() != DEPTH));
      chk("ovf_err", int'(ovf_err), int'(m_ovf));
      chk("out_valid", int'(out_valid), int'(ev));
      if (ev) chk("out_data", int'(out_data), int'(q[0].data));
      if (prev_stall && out_valid) chk("out_data_hold", int'(out_data), prev_data);
      chk("ram_wr_en", int'(ram_wr_en), int'(m_wr_en));
      if (m_wr_en) begin
        chk("ram_wr_addr", int'(ram_wr_addr), m_wr_addr);
        chk("ram_wr_data", int'(ram_wr_data), m_wr_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = int'(out_data);

      if (flush) begin
        q.delete();
        m_ovf = 0; m_wptr = 0; m_wr_en = 0; prev_stall = 0;
      end else begin
        mpush   = in_valid && (q.size() < DEPTH);
        mpop    = ev && out_ready;
        m_wr_en = mpush;
        if (in_valid && !mpush) m_ovf = 1;
        if (mpop) void'(q.pop_front());
        if (mpush) begin
          m_wr_addr = m_wptr;
          m_wr_data = int'(in_data);
          e.data    = in_data;
          e.stamp   = ecount + 1;
          q.push_back(e);
          m_wptr    = (m_wptr + 1) % DEPTH;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int drops;
    int k;
    bit acc;

    // Power-on reset.
    repeat (3) step();
    chk("por_empty", int'(empty), 1);
    chk("por_in_ready", int'(in_ready), 1);
    chk("por_level", int'(level), 0);
    rst_n = 1'b1;
    step();

    // Single byte through an empty FIFO.
    in_valid = 1'b1; in_data = 8'h3C;
    step();
    in_valid = 1'b0;
    chk("sb_wr_en", int'(ram_wr_en), 1);
    chk("sb_wr_addr", int'(ram_wr_addr), 0);
    chk("sb_wr_data", int'(ram_wr_data), 8'h3C);
    chk("sb_level", int'(level), 1);
    step();
    chk("sb_wr_en_low", int'(ram_wr_en), 0);
    step();
    chk("sb_valid_early", int'(out_valid), 0);
    step();
    chk("sb_valid", int'(out_valid), 1);
    chk("sb_data", int'(out_data), 8'h3C);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("sb_level_popped", int'(level), 0);
    chk("sb_empty", int'(empty), 1);
    chk("sb_valid_popped", int'(out_valid), 0);

    // Asynchronous reset with level 5.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(i + 1);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("rt_level5", int'(level), 5);
    chk("rt_valid_before", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rt_level", int'(level), 0);
    chk("rt_empty", int'(empty), 1);
    chk("rt_in_ready", int'(in_ready), 1);
    chk("rt_out_valid", int'(out_valid), 0);
    chk("rt_out_data", int'(out_data), 0);
    chk("rt_wr_addr", int'(ram_wr_addr), 0);
    chk("rt_rd_addr", int'(ram_rd_addr), 0);
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("rt_a5_early", int'(out_valid), 0);
    step();
    chk("rt_a5_valid", int'(out_valid), 1);
    chk("rt_a5_data", int'(out_data), 8'hA5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Fill to full, then overflow.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
    end
    in_valid = 1'b0;
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(level), DEPTH);
    chk("fill_in_ready", int'(in_ready), 0);
    chk("fill_ovf_clear", int'(ovf_err), 0);
    in_valid = 1'b1; in_data = 8'hFF;
    step();
    in_valid = 1'b0;
    chk("ovf_set", int'(ovf_err), 1);
    chk("ovf_level", int'(level), DEPTH);
    chk("ovf_no_write", int'(ram_wr_en), 0);

    // Drain down to 100, then stream across the read-pointer wrap.
    out_ready = 1'b1;
    n = 0;
    while (int'(level) != 100 && n < 40000) begin
      step();
      n++;
    end
    chk("drain_to_100", int'(level), 100);
    drops = 0;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      if (!out_valid) drops++;
      step();
    end
    in_valid = 1'b0;
    chk("stream_drops", drops, 0);
    chk("stream_level", int'(level), 100);
    n = 0;
    while (!empty && n < 500) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    chk("drain_empty", int'(empty), 1);
    chk("ovf_sticky", int'(ovf_err), 1);

    // Random backpressure against a continuous push stream.
    k = 0;
    for (int i = 0; i < 2000; i++) begin
      in_valid  = 1'b1;
      in_data   = 8'((k * 7) + 3);
      out_ready = 1'($urandom_range(0, 1));
      acc       = in_ready;
      step();
      if (acc) k++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (!empty && n < 3000) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    chk("bp_empty", int'(empty), 1);

    // Flush with a push and an in-flight read.
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_data = 8'(8'hC0 + i);
      step();
    end
    in_valid = 1'b0;
    repeat (4) step();
    chk("fl_level11", int'(level), 11);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("fl_level10", int'(level), 10);
    chk("fl_ovf_before", int'(ovf_err), 1);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_level", int'(level), 0);
    chk("fl_empty", int'(empty), 1);
    chk("fl_out_valid", int'(out_valid), 0);
    chk("fl_ovf", int'(ovf_err), 0);
    chk("fl_no_write", int'(ram_wr_en), 0);
    step();
    chk("fl_stale_read", int'(out_valid), 0);
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    chk("fl_wr_en", int'(ram_wr_en), 1);
    chk("fl_wr_addr", int'(ram_wr_addr), 0);
    step(); step();
    chk("fl_rd_addr", int'(ram_rd_addr), 0);
    step();
    chk("fl_valid", int'(out_valid), 1);
    chk("fl_data", int'(out_data), 8'h5A);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("fl_final_empty", int'(empty), 1);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
